deployment_test_sending_block: RTL and testbench
================================================

Name: deployment_test_sending_block

Overview:
- Packet source stage for the deployment test path.
- Latches one wide test packet on a start pulse and serialises it LSB-first into NUM_TRANSFERS AXI-Stream beats of NUM_BITS_PER_TRANSFER payload bits each.
- Sits directly upstream of deployment_test_receiving_block, which reassembles the beats and compares them against the same expected packet.
- Reports beat progress and a one-cycle completion pulse.

Parameters:
- AXIS_DATA_WIDTH, 56, TDATA width; must be >= NUM_BITS_PER_TRANSFER.
- NUM_TRANSFERS, 16, beats per packet; must be >= 1.
- NUM_BITS_PER_TRANSFER, 49, payload bits per beat. PACKET_SIZE = NUM_TRANSFERS*NUM_BITS_PER_TRANSFER (784).
- GAP_CYCLES, 4, idle cycles inserted between beats; used only when the optional feature is compiled in; must be >= 1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_packet  in  PACKET_SIZE  packet to send; sampled only when a start is accepted.
- i_start  in  1  start request; honoured only in IDLE.
- o_test_axis_TVALID  out  1  AXIS valid.
- i_test_axis_TREADY  in  1  AXIS ready.
- o_test_axis_TDATA  out  AXIS_DATA_WIDTH  beat payload in [NUM_BITS_PER_TRANSFER-1:0]; upper bits always 0.
- o_test_axis_TLAST  out  1  high on the final beat only.
- o_busy  out  1  high whenever not in IDLE.
- o_done  out  1  one-cycle pulse after the final handshake.
- o_beat_count  out  $clog2(NUM_TRANSFERS+1)  number of beats accepted in the current packet.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, shift register 0, gap counter 0. Reset has priority over every other event.
- FSM states:
  - IDLE: on i_start=1, load i_packet into the shift register, clear o_beat_count, go to SEND. With i_start=0, stay in IDLE.
  - SEND: TVALID=1. TDATA = shreg[NUM_BITS_PER_TRANSFER-1:0], zero-extended. TLAST = (o_beat_count == NUM_TRANSFERS-1).
    - Handshake (TVALID & TREADY): shift shreg right by NUM_BITS_PER_TRANSFER and increment o_beat_count.
    - If the handshake is on the last beat, go to DONE. Otherwise stay in SEND, or go to GAP when the optional feature is compiled in.
  - GAP (optional feature only): TVALID=0. Count GAP_CYCLES cycles, then return to SEND.
  - DONE: o_done=1 and o_busy=1 for exactly one cycle, then go to IDLE.
- Latency:
  - Start accepted at edge N: beat 0 is valid after edge N.
  - With TREADY held high and the feature off, beats are back-to-back (one per cycle).
  - From start to o_done: NUM_TRANSFERS+1 cycles.
- AXIS rules:
  - Once TVALID is high, it, TDATA and TLAST hold stable until the handshake.
  - TVALID never depends combinationally on TREADY.
- Start handling:
  - i_start while busy (SEND/GAP/DONE) is ignored, not queued.
  - i_start in the cycle o_done is high is ignored; a new start is accepted from IDLE on the next cycle.
- Changes to i_packet after the start is accepted have no effect on the packet in flight.
- o_beat_count stays at NUM_TRANSFERS after completion until the next accepted start.
- Reset mid-packet: the next edge drops TVALID and returns to IDLE; no o_done pulse is generated.
- NUM_TRANSFERS=1: the single beat carries TLAST=1; o_done follows on the next cycle.

Optional Feature:
- Macro: DEPLOYMENT_TEST_SEND_GAP_EN.
- When defined: after every accepted beat except the last, TVALID is low for exactly GAP_CYCLES cycles (GAP state). This exercises the receiver's handling of idle gaps. Start to o_done with TREADY held high takes NUM_TRANSFERS+1+(NUM_TRANSFERS-1)*GAP_CYCLES cycles.
- When undefined: no GAP state and no gap counter logic; beats are back-to-back.

Test Plan:
- Defaults, 784-bit packet ...596600 (low bits 0x596600), TREADY=1, one start pulse -> 16 consecutive beats; beat0 TDATA[48:0] = packet[48:0] with TDATA[55:49]=0; TLAST only on beat 15; o_done one cycle later; o_beat_count=16.
- Config AXIS_DATA_WIDTH=8, NUM_TRANSFERS=8, NUM_BITS_PER_TRANSFER=8, packet 64'h8BD59FCA6E0E9B4E -> TDATA sequence 4E,9B,0E,6E,CA,9F,D5,8B.
- TREADY toggled 1,0,1,0 -> each beat holds TDATA/TVALID stable while TREADY=0; total 16 handshakes; o_done after 32 cycles.
- i_start pulsed again at beat 5 and in the o_done cycle -> no restart and beat order unchanged; a start one cycle after o_done sends the new packet correctly.
- i_reset asserted after beat 5 handshake -> TVALID=0 and o_beat_count=0 next cycle; no o_done; a following start sends from beat 0.
- DEPLOYMENT_TEST_SEND_GAP_EN defined, GAP_CYCLES=4, TREADY=1 -> TVALID high 1 cycle then low 4 cycles, repeating; o_done at cycle 77 after start.

Source files
------------

// File: rtl/deployment_test_sending_block.sv
// Packet source: latches one wide packet on start and streams it LSB-first as AXI-Stream beats.
// Optional inter-beat idle gaps are enabled with the DEPLOYMENT_TEST_SEND_GAP_EN macro.
module deployment_test_sending_block #(
    parameter int AXIS_DATA_WIDTH       = 56,
    parameter int NUM_TRANSFERS         = 16,
    parameter int NUM_BITS_PER_TRANSFER = 49,
    parameter int GAP_CYCLES            = 4
) (
    input  logic                                             i_clk,
    input  logic                                             i_reset,
    input  logic [NUM_TRANSFERS*NUM_BITS_PER_TRANSFER-1:0]   i_packet,
    input  logic                                             i_start,
    output logic                                             o_test_axis_TVALID,
    input  logic                                             i_test_axis_TREADY,
    output logic [AXIS_DATA_WIDTH-1:0]                       o_test_axis_TDATA,
    output logic                                             o_test_axis_TLAST,
    output logic                                             o_busy,
    output logic                                             o_done,
    output logic [$clog2(NUM_TRANSFERS+1)-1:0]               o_beat_count
);

    localparam int PACKET_SIZE = NUM_TRANSFERS * NUM_BITS_PER_TRANSFER;
    localparam int BW          = $clog2(NUM_TRANSFERS + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_TRANSFERS - 1);

    if (GAP_CYCLES < 1 || NUM_TRANSFERS < 1 || AXIS_DATA_WIDTH < NUM_BITS_PER_TRANSFER) begin : g_bad_params
        $error("deployment_test_sending_block: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
`ifdef DEPLOYMENT_TEST_SEND_GAP_EN
        , ST_GAP = 2'd3
`endif
    } state_t;

    state_t                 state_q;
    logic [PACKET_SIZE-1:0] shreg_q;
    logic [PACKET_SIZE-1:0] shreg_d;
    logic [BW-1:0]          beat_q;
    logic [BW-1:0]          beat_d;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;

`ifdef DEPLOYMENT_TEST_SEND_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    logic [GW-1:0] gap_q;
`endif

    assign shreg_d = shreg_q >> NUM_BITS_PER_TRANSFER;
    assign beat_d  = beat_q + BW'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DEPLOYMENT_TEST_SEND_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        shreg_q <= i_packet;
                        beat_q  <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // valid_q is high throughout SEND, so TREADY alone marks the handshake
                    if (i_test_axis_TREADY) begin
                        shreg_q <= shreg_d;
                        beat_q  <= beat_d;
                        if (beat_q == LAST_BEAT) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
`ifdef DEPLOYMENT_TEST_SEND_GAP_EN
                        else begin
                            valid_q <= 1'b0;
                            gap_q   <= '0;
                            state_q <= ST_GAP;
                        end
`endif
                    end
                end
`ifdef DEPLOYMENT_TEST_SEND_GAP_EN
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_SEND;
                    end else begin
                        gap_q   <= gap_q + GW'(1);
                    end
                end
`endif
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_test_axis_TDATA = '0;
        o_test_axis_TDATA[NUM_BITS_PER_TRANSFER-1:0] = shreg_q[NUM_BITS_PER_TRANSFER-1:0];
    end

    assign o_test_axis_TVALID = valid_q;
    assign o_test_axis_TLAST  = valid_q & (beat_q == LAST_BEAT);
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_beat_count       = beat_q;

endmodule

// File: tb/tb_deployment_test_sending_block.sv
// Self-checking bench for deployment_test_sending_block: randomized packets and TREADY patterns
// checked against a beat-index model of the packet stream.
module tb_deployment_test_sending_block;

    localparam int DW = 56;
    localparam int NT = 16;
    localparam int NB = 49;
    localparam int G  = 4;
    localparam int PS = NT * NB;
    localparam int BW = $clog2(NT + 1);
`ifdef DEPLOYMENT_TEST_SEND_GAP_EN
    localparam int GAPS = G;
`else
    localparam int GAPS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [PS-1:0] packet;
    logic          start;
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          busy;
    logic          done;
    logic [BW-1:0] beat_count;

    int tests = 0;
    int fails = 0;

    deployment_test_sending_block #(
        .AXIS_DATA_WIDTH      (DW),
        .NUM_TRANSFERS        (NT),
        .NUM_BITS_PER_TRANSFER(NB),
        .GAP_CYCLES           (G)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_packet          (packet),
        .i_start           (start),
        .o_test_axis_TVALID(tvalid),
        .i_test_axis_TREADY(tready),
        .o_test_axis_TDATA (tdata),
        .o_test_axis_TLAST (tlast),
        .o_busy            (busy),
        .o_done            (done),
        .o_beat_count      (beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PS-1:0] rand_packet();
        logic [PS-1:0] p = '0;
        for (int i = 0; i < (PS + 31) / 32; i++) p = (p << 32) | PS'($urandom);
        return p;
    endfunction

    // Beat k of a packet is simply bits [k*NB +: NB], zero-extended onto the bus.
    function automatic logic [63:0] exp_beat(input logic [PS-1:0] pkt, input int k);
        logic [PS-1:0] t;
        t = pkt >> (k * NB);
        return 64'(t[NB-1:0]);
    endfunction

    // mode: 0 = TREADY held high, 1 = TREADY toggles 1,0,1,0, 2 = random TREADY
    task automatic run_packet(input logic [PS-1:0] pkt, input int mode, input int restart_beat,
                              input int reset_after, input bit start_in_done);
        int k = 0;
        int cyc = 0;
        int gap_left = 0;
        int budget = 4 * NT * (GAPS + 2) + 8;
        bit exp_valid, rdy, hs, aborted;
        aborted = 1'b0;
        @(negedge clk);
        packet = pkt;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        packet = rand_packet();
        while (k < NT) begin
            if (cyc > budget) begin
                check("cycle_budget", 64'(cyc), 64'(budget));
                break;
            end
            if (reset_after >= 0 && k == reset_after + 1) begin
                aborted = 1'b1;
                break;
            end
            exp_valid = (gap_left == 0);
            check("tvalid", 64'(tvalid), 64'(exp_valid));
            check("busy", 64'(busy), 64'(1));
            check("done_early", 64'(done), 64'(0));
            if (exp_valid) begin
                check("tdata", 64'(tdata), exp_beat(pkt, k));
                check("tlast", 64'(tlast), 64'(k == NT - 1));
                check("beat_count", 64'(beat_count), 64'(k));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tready = rdy;
            start  = (k == restart_beat);
            hs = exp_valid && rdy;
            @(posedge clk);
            @(negedge clk);
            if (!exp_valid) gap_left--;
            if (hs) begin
                k++;
                if (k < NT) gap_left = GAPS;
            end
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            check("rst_tvalid", 64'(tvalid), 64'(0));
            check("rst_beat_count", 64'(beat_count), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            for (int i = 0; i < 3; i++) begin
                check("rst_no_done", 64'(done), 64'(0));
                @(posedge clk);
                @(negedge clk);
            end
            $display("[TB] packet aborted by reset after beat %0d", reset_after);
            return;
        end
        check("done_pulse", 64'(done), 64'(1));
        check("done_busy", 64'(busy), 64'(1));
        check("done_tvalid", 64'(tvalid), 64'(0));
        check("done_beat_count", 64'(beat_count), 64'(NT));
        if (mode == 0)
            check("cycles_to_done", 64'(cyc), 64'(NT + (NT - 1) * GAPS));
        else if (mode == 1 && GAPS == 0)
            check("cycles_to_done", 64'(cyc), 64'(2 * NT - 1));
        start = start_in_done;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("idle_done", 64'(done), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_tvalid", 64'(tvalid), 64'(0));
        check("idle_beat_count", 64'(beat_count), 64'(NT));
        $display("[TB] packet sent: %0d beats, mode %0d, %0d cycles start to done", NT, mode, cyc);
    endtask

    initial begin
        logic [PS-1:0] p;
        rst    = 1'b1;
        start  = 1'b0;
        tready = 1'b0;
        packet = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_tvalid", 64'(tvalid), 64'(0));
        check("reset_tdata", 64'(tdata), 64'(0));
        check("reset_tlast", 64'(tlast), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_beat_count", 64'(beat_count), 64'(0));
        rst = 1'b0;

        p = rand_packet();
        p[23:0] = 24'h596600;
        run_packet(p, 0, -1, -1, 1'b0);
        run_packet(rand_packet(), 1, -1, -1, 1'b0);
        run_packet(rand_packet(), 0, 5, -1, 1'b1);
        run_packet(rand_packet(), 2, -1, -1, 1'b0);
        run_packet(rand_packet(), 0, -1, 5, 1'b0);
        run_packet(rand_packet(), 2, 3, -1, 1'b1);
        for (int i = 0; i < 3; i++) run_packet(rand_packet(), 2, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
